pipe_mux_skid: RTL and testbench
================================

Name: pipe_mux_skid

Overview:
- Parametrised, registered N:1 datapath multiplexer with a valid/ready handshake and a 2-entry skid buffer.
- Supersedes the fixed 3:1 combinational 32-bit select for pipeline-stage boundaries in the MIPS datapath, such as ALU operand and forwarding selection.
- Lets a downstream stall back-pressure the upstream without dropping or duplicating a beat.
- Flags out-of-range selects and keeps a saturating count of them.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_INPUTS, 3, number of data inputs; legal range 2..16.
- SEL_W, 2, select width; 2**SEL_W >= NUM_INPUTS is required.
- ERR_CNT_W, 8, width of the saturating out-of-range select counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat.
- sel  input  SEL_W  input index, sampled with the beat.
- data_in  input  NUM_INPUTS*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts the beat.
- data_out  output  WIDTH  selected data of the current output beat.
- out_sel_err  output  1  the current output beat had sel >= NUM_INPUTS.
- err_count  output  ERR_CNT_W  saturating count of accepted out-of-range beats.

Behaviour:
- Reset is synchronous, active-high, on the clk rising edge. While rst is high and on the first cycle after:
  - out_valid=0, data_out=0, out_sel_err=0, err_count=0.
  - Skid entry is empty.
  - in_ready=0 while rst is high and 1 on the first cycle after rst falls.
- Reset mid-operation discards every held beat, both the output register and the skid entry. No beat is emitted after reset until a new beat is accepted.
- Select rule:
  - sel < NUM_INPUTS selects data_in[sel*WIDTH +: WIDTH].
  - sel >= NUM_INPUTS selects the highest input (NUM_INPUTS-1), matching the existing default-to-last-input convention, and sets the beat's err flag.
- Accept/deliver handshake:
  - An input beat is accepted when in_valid && in_ready at a rising edge.
  - An output beat is delivered when out_valid && out_ready.
- Storage: main output register (data, err) plus one skid entry (data, err, valid).
- in_ready is a register output equal to NOT skid_valid. It has no combinational path from out_ready.
- Latency: an accepted beat appears on data_out the next cycle when the main register is empty or being drained. Otherwise it waits in the skid entry.
- Per-edge update, when not in reset:
  - Main register empty, or delivered this edge:
    - If the skid entry is valid, the skid moves to main and the skid empties. If a beat is also accepted this edge, it goes into the skid (cannot occur, since in_ready=0 when the skid is full).
    - Else, an accepted beat loads main.
    - Else, main empties.
  - Main register full and not delivered:
    - An accepted beat loads the skid.
    - data_out and out_sel_err hold stable.
- Order is strictly FIFO. No beat is dropped or duplicated.
- Throughput is 1 beat/cycle with out_ready held high.
- data_out and out_sel_err must not change while out_valid && !out_ready.
- err_count increments by 1 on each accepted beat with sel >= NUM_INPUTS and saturates at 2**ERR_CNT_W-1. It is cleared only by rst.
- data_out holds its last value when out_valid=0; only out_valid qualifies it.

Test Plan:
- Reset, then defaults: assert rst 3 cycles mid-stream with 2 beats held → next cycle out_valid=0, data_out=0, err_count=0, in_ready=1 after rst falls, held beats never appear.
- Streaming: NUM_INPUTS=3, inputs {0xA0,0xB1,0xC2}, out_ready=1, sel sequence 0,1,2,1 on consecutive cycles → data_out 0xA0,0xB1,0xC2,0xB1, each 1 cycle after acceptance, out_valid continuous.
- Stall/skid: out_ready=0 with beats 0x11 then 0x22 offered → main=0x11, skid=0x22, in_ready=0, a third beat 0x33 is not accepted. Raise out_ready → 0x11, 0x22, 0x33 delivered in order, in_ready returns to 1.
- Out-of-range select: NUM_INPUTS=3, SEL_W=2, sel=3 with input 2=0xDEADBEEF → data_out=0xDEADBEEF, out_sel_err=1, err_count=1. Next beat sel=0 → out_sel_err=0.
- Counter saturation: ERR_CNT_W=2, five accepted sel=3 beats → err_count 1,2,3,3,3.
- Randomised back-pressure: random in_valid/out_ready for 10k cycles, scoreboard → output sequence equals accepted sequence with correct selection, and data is stable during stalls.

Source files
------------

// File: rtl/pipe_mux_skid_if.sv
// pipe_mux_skid_if: valid/ready handshake and data bus for the registered N:1 mux.
interface pipe_mux_skid_if #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 3,
    parameter int SEL_W      = 2,
    parameter int ERR_CNT_W  = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic [SEL_W-1:0]            sel;
    logic [NUM_INPUTS*WIDTH-1:0] data_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            data_out;
    logic                        out_sel_err;
    logic [ERR_CNT_W-1:0]        err_count;

    modport master (
        output in_valid, sel, data_in, out_ready,
        input  in_ready, out_valid, data_out, out_sel_err, err_count
    );

    modport slave (
        input  in_valid, sel, data_in, out_ready,
        output in_ready, out_valid, data_out, out_sel_err, err_count
    );
endinterface

// File: rtl/pipe_mux_skid.sv
// pipe_mux_skid: registered N:1 select with valid/ready handshake, 2-entry skid
// buffer, out-of-range select flag and saturating error counter.
module pipe_mux_skid #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 3,
    parameter int SEL_W      = 2,
    parameter int ERR_CNT_W  = 8
) (
    input logic            clk,
    input logic            rst,
    pipe_mux_skid_if.slave bus
);
    logic [WIDTH-1:0]     w_sel_data;
    logic                 w_sel_err;
    logic                 w_acc;
    logic                 w_drain;
    logic                 w_skid_nxt;
    logic                 r_main_valid;
    logic [WIDTH-1:0]     r_main_data;
    logic                 r_main_err;
    logic                 r_skid_valid;
    logic [WIDTH-1:0]     r_skid_data;
    logic                 r_skid_err;
    logic                 r_in_ready;
    logic [ERR_CNT_W-1:0] r_err_count;

    // Out-of-range selects fall back to the highest input.
    always_comb begin
        w_sel_err  = 32'(bus.sel) >= NUM_INPUTS;
        w_sel_data = '0;
        for (int k = 0; k < NUM_INPUTS; k++)
            if (32'(bus.sel) == k || (w_sel_err && k == NUM_INPUTS - 1))
                w_sel_data = bus.data_in[k*WIDTH +: WIDTH];
    end

    assign w_acc      = bus.in_valid && r_in_ready;
    assign w_drain    = !r_main_valid || bus.out_ready;
    assign w_skid_nxt = w_drain ? (r_skid_valid && w_acc) : (r_skid_valid || w_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_err   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_err   <= 1'b0;
            r_in_ready   <= 1'b0;
            r_err_count  <= '0;
        end else begin
            if (w_drain) begin
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= r_skid_data;
                    r_main_err   <= r_skid_err;
                    if (w_acc) begin
                        r_skid_data <= w_sel_data;
                        r_skid_err  <= w_sel_err;
                    end
                end else begin
                    r_main_valid <= w_acc;
                    if (w_acc) begin
                        r_main_data <= w_sel_data;
                        r_main_err  <= w_sel_err;
                    end
                end
            end else if (w_acc) begin
                r_skid_data <= w_sel_data;
                r_skid_err  <= w_sel_err;
            end
            r_skid_valid <= w_skid_nxt;
            // Registered ready: no combinational path from out_ready.
            r_in_ready   <= !w_skid_nxt;
            if (w_acc && w_sel_err && r_err_count != '1)
                r_err_count <= r_err_count + 1'b1;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_main_valid;
    assign bus.data_out    = r_main_data;
    assign bus.out_sel_err = r_main_err;
    assign bus.err_count   = r_err_count;
endmodule

// File: tb/tb_pipe_mux_skid.sv
// tb_pipe_mux_skid: directed and randomised stimulus against a queue-based
// FIFO reference model of the registered mux.
module tb_pipe_mux_skid;
    localparam int NI = 3;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    n_vec = 0;
    int    n_err = 0;
    beat_t q[$];
    beat_t m_last;
    logic  m_rdy;
    int    m_cnt;

    pipe_mux_skid_if #(.WIDTH(32), .NUM_INPUTS(NI), .SEL_W(2), .ERR_CNT_W(8)) b ();

    pipe_mux_skid #(.WIDTH(32), .NUM_INPUTS(NI), .SEL_W(2), .ERR_CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [1:0] s, input logic ordy,
                       input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic        acc;
        logic        dlv;
        logic [31:0] w[NI];
        int          k;
        @(negedge clk);
        chk("out_valid", 64'(b.out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(b.in_ready), 64'(m_rdy));
        chk("data_out", 64'(b.data_out), 64'(q.size() > 0 ? q[0].d : m_last.d));
        chk("out_sel_err", 64'(b.out_sel_err), 64'(q.size() > 0 ? q[0].e : m_last.e));
        chk("err_count", 64'(b.err_count), 64'(m_cnt));
        w[0] = w0; w[1] = w1; w[2] = w2;
        rst         = r;
        b.in_valid  = v;
        b.sel       = s;
        b.out_ready = ordy;
        b.data_in   = {w2, w1, w0};
        acc = v && m_rdy;
        dlv = (q.size() > 0) && ordy;
        if (r) begin
            q.delete();
            m_cnt  = 0;
            m_rdy  = 1'b0;
            m_last = '{32'd0, 1'b0};
        end else begin
            if (dlv) m_last = q.pop_front();
            if (acc) begin
                k = (int'(s) >= NI) ? NI - 1 : int'(s);
                q.push_back('{w[k], int'(s) >= NI});
                if (int'(s) >= NI && m_cnt < 255) m_cnt++;
            end
            m_rdy = q.size() < 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 1'b1, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        b.in_valid  = 1'b0;
        b.sel       = '0;
        b.out_ready = 1'b0;
        b.data_in   = '0;
        repeat (2) @(posedge clk);
        m_rdy  = 1'b0;
        m_cnt  = 0;
        m_last = '{32'd0, 1'b0};
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        idle(2);
        // Streaming at full rate.
        cyc(1'b0, 1'b1, 2'd0, 1'b1, 32'hA0, 32'hB1, 32'hC2);
        cyc(1'b0, 1'b1, 2'd1, 1'b1, 32'hA0, 32'hB1, 32'hC2);
        cyc(1'b0, 1'b1, 2'd2, 1'b1, 32'hA0, 32'hB1, 32'hC2);
        cyc(1'b0, 1'b1, 2'd1, 1'b1, 32'hA0, 32'hB1, 32'hC2);
        idle(2);
        // Stall fills main and skid; third beat is refused until space frees.
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'h22, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'h33, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'h33, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 2'd0, 1'b1, 32'h33, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 2'd0, 1'b1, 32'h33, 32'h0, 32'h0);
        idle(3);
        // Out-of-range select.
        cyc(1'b0, 1'b1, 2'd3, 1'b1, 32'h1, 32'h2, 32'hDEADBEEF);
        cyc(1'b0, 1'b1, 2'd0, 1'b1, 32'h5, 32'h6, 32'h7);
        idle(2);
        // Mid-stream reset with two beats held.
        cyc(1'b0, 1'b1, 2'd3, 1'b0, 32'h44, 32'h55, 32'h66);
        cyc(1'b0, 1'b1, 2'd1, 1'b0, 32'h44, 32'h55, 32'h66);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2'd0, 1'b1, 32'h77, 32'h0, 32'h0);
        idle(3);
        // Randomised traffic and back-pressure; error count saturates along the way.
        for (int i = 0; i < 10000; i++)
            cyc(1'b0, ($urandom % 4) != 0, 2'($urandom % 4), ($urandom % 3) != 0,
                $urandom, $urandom, $urandom);
        idle(3);
        chk("err_count_sat", 64'(b.err_count), 64'd255);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
